geofence_host: RTL and testbench

- Host-side transmitter/collector for the geofence engine.
- Fetches objects from a point memory. Each object is 6 records of {X,Y,R}.
- Streams each object to the engine as the 6-cycle burst the engine samples, then waits for the engine's valid/is_inside pulse.
- Reports one result per object and a running inside count.

---
 rtl/geofence_host.sv | 248 ++++++++++++++++++++++++
 tb/tb_geofence_host.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/geofence_host.sv
// geofence_host: fetches 6-point objects from point memory, streams each
// object to the geofence engine as a 6-cycle burst and collects its result.
// Optional macro GEOFENCE_HOST_TIMEOUT_EN adds a WAITV watchdog and err_cnt.
//
// Ports:
//   clk, reset (async, active-low)
//   start, num_obj          run request, object count sampled on start
//   busy, done              run status, done is a one-cycle pulse
//   mem_rd, mem_addr        memory read strobe/address (obj*6 + k)
//   mem_data                {X,Y,R}, valid one cycle after mem_rd
//   gf_reset, gf_X/Y/R      engine reset and point bus
//   gf_valid, gf_is_inside  engine result strobe and result bit
//   res_valid, res_idx, res_inside, inside_cnt   per-object result
//   err_cnt                 timed-out objects (GEOFENCE_HOST_TIMEOUT_EN only)
module geofence_host #(
    parameter int ADDR_W  = 11,
    parameter int NOBJ_W  = 8,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [NOBJ_W-1:0] num_obj,
    output logic              busy,
    output logic              done,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [30:0]       mem_data,
    output logic              gf_reset,
    output logic [9:0]        gf_X,
    output logic [9:0]        gf_Y,
    output logic [10:0]       gf_R,
    input  logic              gf_valid,
    input  logic              gf_is_inside,
    output logic              res_valid,
    output logic [NOBJ_W-1:0] res_idx,
    output logic              res_inside,
`ifdef GEOFENCE_HOST_TIMEOUT_EN
    output logic [NOBJ_W-1:0] err_cnt,
`endif
    output logic [NOBJ_W-1:0] inside_cnt
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_GFRST = 3'd2;
    localparam logic [2:0] S_SEND  = 3'd3;
    localparam logic [2:0] S_WAITV = 3'd4;

    // A zero watchdog period is meaningless; nothing is built for it.
    if (TIMEOUT < 1) begin : g_timeout_invalid
    end

    logic [2:0]        state;
    logic [NOBJ_W-1:0] nobj;
    logic [NOBJ_W-1:0] obj;
    logic [ADDR_W-1:0] base;
    logic [2:0]        rd_k;
    logic [2:0]        wr_k;
    logic              pend;
    logic              full;
    logic [2:0]        s_k;
    logic              g_cnt;
    logic [30:0]       pbuf [6];

    logic              full_next;
    logic              last;
    logic              fetch_go;
    logic [ADDR_W-1:0] fetch_base;
    logic              got_res;
    logic              tmo;
    logic              res_evt;

`ifdef GEOFENCE_HOST_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tcnt;
    assign tmo = (state == S_WAITV) && !gf_valid &&
                 (tcnt == TW'(TIMEOUT - 1));
`else
    assign tmo = 1'b0;
`endif

    // The last buffer entry lands at this edge.
    assign full_next = pend && (wr_k == 3'd5);
    assign last      = (obj == nobj - NOBJ_W'(1));
    assign got_res   = (state == S_WAITV) && gf_valid;
    assign res_evt   = got_res || tmo;

    // Next object's fetch overlaps WAITV: it is launched as SEND ends.
    always_comb begin
        fetch_go   = 1'b0;
        fetch_base = base + ADDR_W'(6);
        if (state == S_IDLE && start && num_obj != '0) begin
            fetch_go   = 1'b1;
            fetch_base = '0;
        end else if (state == S_SEND && s_k == 3'd5 && !last) begin
            fetch_go = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_rd   <= 1'b0;
            mem_addr <= '0;
            rd_k     <= '0;
            wr_k     <= '0;
            pend     <= 1'b0;
            full     <= 1'b0;
        end else begin
            pend <= mem_rd;
            if (fetch_go) begin
                mem_rd   <= 1'b1;
                mem_addr <= fetch_base;
                rd_k     <= '0;
                wr_k     <= '0;
                full     <= 1'b0;
            end else begin
                if (mem_rd) begin
                    if (rd_k == 3'd5) begin
                        mem_rd <= 1'b0;
                    end else begin
                        mem_addr <= mem_addr + ADDR_W'(1);
                        rd_k     <= rd_k + 3'd1;
                    end
                end
                if (pend) begin
                    wr_k <= wr_k + 3'd1;
                    if (wr_k == 3'd5) full <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (pend && wr_k < 3'd6) pbuf[wr_k] <= mem_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            gf_reset   <= 1'b1;
            gf_X       <= '0;
            gf_Y       <= '0;
            gf_R       <= '0;
            res_valid  <= 1'b0;
            res_idx    <= '0;
            res_inside <= 1'b0;
            inside_cnt <= '0;
            nobj       <= '0;
            obj        <= '0;
            base       <= '0;
            s_k        <= '0;
            g_cnt      <= 1'b0;
`ifdef GEOFENCE_HOST_TIMEOUT_EN
            err_cnt    <= '0;
            tcnt       <= '0;
`endif
        end else begin
            done      <= 1'b0;
            res_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        inside_cnt <= '0;
                        obj        <= '0;
                        base       <= '0;
                        nobj       <= num_obj;
`ifdef GEOFENCE_HOST_TIMEOUT_EN
                        err_cnt    <= '0;
`endif
                        if (num_obj == '0) begin
                            done <= 1'b1;
                        end else begin
                            busy  <= 1'b1;
                            state <= S_FETCH;
                        end
                    end
                end
                S_FETCH: begin
                    if (full_next) begin
                        state <= S_GFRST;
                        g_cnt <= 1'b0;
                    end
                end
                S_GFRST: begin
                    if (g_cnt) begin
                        state              <= S_SEND;
                        s_k                <= '0;
                        gf_reset           <= 1'b0;
                        {gf_X, gf_Y, gf_R} <= pbuf[0];
                    end else begin
                        g_cnt <= 1'b1;
                    end
                end
                S_SEND: begin
                    if (s_k == 3'd5) begin
                        {gf_X, gf_Y, gf_R} <= '0;
                        state              <= S_WAITV;
`ifdef GEOFENCE_HOST_TIMEOUT_EN
                        tcnt               <= '0;
`endif
                    end else begin
                        {gf_X, gf_Y, gf_R} <= pbuf[s_k + 3'd1];
                        s_k                <= s_k + 3'd1;
                    end
                end
                S_WAITV: begin
`ifdef GEOFENCE_HOST_TIMEOUT_EN
                    tcnt <= tcnt + TW'(1);
                    if (tmo) err_cnt <= err_cnt + NOBJ_W'(1);
`endif
                    if (res_evt) begin
                        res_valid  <= 1'b1;
                        res_idx    <= obj;
                        res_inside <= got_res && gf_is_inside;
                        if (got_res && gf_is_inside)
                            inside_cnt <= inside_cnt + NOBJ_W'(1);
                        if (last) begin
                            done     <= 1'b1;
                            busy     <= 1'b0;
                            gf_reset <= 1'b1;
                            state    <= S_IDLE;
                        end else begin
                            obj  <= obj + NOBJ_W'(1);
                            base <= base + ADDR_W'(6);
                            if (full && !tmo) begin
                                state              <= S_SEND;
                                s_k                <= '0;
                                {gf_X, gf_Y, gf_R} <= pbuf[0];
                            end else begin
                                // Engine must be re-reset before the
                                // next burst.
                                gf_reset <= 1'b1;
                                g_cnt    <= 1'b0;
                                state    <= (full || full_next) ?
                                            S_GFRST : S_FETCH;
                            end
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_geofence_host.sv
// tb_geofence_host: randomized runs of geofence_host against a per-cycle
// expected waveform computed from the host's timing rules.
module tb_geofence_host;

    localparam int MAXC = 1024;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  num_obj = '0;
    logic        busy, done, mem_rd;
    logic [10:0] mem_addr;
    logic [30:0] mem_data = '0;
    logic        gf_reset;
    logic [9:0]  gf_X, gf_Y;
    logic [10:0] gf_R;
    logic        gf_valid = 1'b0;
    logic        gf_is_inside = 1'b0;
    logic        res_valid;
    logic [7:0]  res_idx;
    logic        res_inside;
    logic [7:0]  inside_cnt;
`ifdef GEOFENCE_HOST_TIMEOUT_EN
    logic [7:0]  err_cnt;
`endif

    geofence_host dut (
        .clk(clk), .reset(reset), .start(start), .num_obj(num_obj),
        .busy(busy), .done(done), .mem_rd(mem_rd), .mem_addr(mem_addr),
        .mem_data(mem_data), .gf_reset(gf_reset),
        .gf_X(gf_X), .gf_Y(gf_Y), .gf_R(gf_R),
        .gf_valid(gf_valid), .gf_is_inside(gf_is_inside),
        .res_valid(res_valid), .res_idx(res_idx), .res_inside(res_inside),
`ifdef GEOFENCE_HOST_TIMEOUT_EN
        .err_cnt(err_cnt),
`endif
        .inside_cnt(inside_cnt)
    );

    always #5 clk = ~clk;

    logic [30:0] mem [2048];

    // Memory answers one cycle after the read strobe; junk otherwise.
    always @(posedge clk) mem_data <= mem_rd ? mem[mem_addr] : 31'($urandom);

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h",
                     tag, $time, got, exp);
        end
    endtask

    bit          e_busy [MAXC];
    bit          e_done [MAXC];
    bit          e_rd   [MAXC];
    bit          e_gfr  [MAXC];
    bit          e_res  [MAXC];
    bit          e_ins  [MAXC];
    bit          e_gfv  [MAXC];
    bit          e_gvin [MAXC];
    bit          e_win  [MAXC];
    int          e_addr [MAXC];
    int          e_idx  [MAXC];
    int          e_cnt  [MAXC];
    logic [30:0] e_pt   [MAXC];
    int          e_end;
    int          e_vlast;
    int          lat [8];
    bit          ins [8];

    // Expected waveform, cycle 0 = first cycle after the start edge.
    task automatic build(input int n);
        int s, e, v, f;
        for (int c = 0; c < MAXC; c++) begin
            e_busy[c] = 0; e_done[c] = 0; e_rd[c] = 0; e_gfr[c] = 1;
            e_res[c] = 0; e_ins[c] = 0; e_gfv[c] = 0; e_gvin[c] = 0;
            e_win[c] = 0; e_addr[c] = 0; e_idx[c] = 0; e_cnt[c] = 0;
            e_pt[c] = '0;
        end
        e_vlast = -1;
        if (n == 0) begin
            e_done[0] = 1;
            e_end = 4;
            return;
        end
        for (int k = 0; k < 6; k++) begin
            e_rd[k] = 1;
            e_addr[k] = k;
        end
        s = 9;
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < 6; k++)
                e_pt[s + k] = mem[(6 * i + k) % 2048];
            e = s + 5;
            v = e + lat[i];
            for (int c = s; c <= v; c++) e_gfr[c] = 0;
            for (int c = e + 1; c <= v; c++) e_win[c] = 1;
            e_gfv[v] = 1;
            e_gvin[v] = ins[i];
            e_res[v + 1] = 1;
            e_idx[v + 1] = i;
            e_ins[v + 1] = ins[i];
            for (int c = v + 1; c < MAXC; c++) e_cnt[c] += int'(ins[i]);
            if (i < n - 1) begin
                for (int k = 0; k < 6; k++) begin
                    e_rd[e + 1 + k] = 1;
                    e_addr[e + 1 + k] = (6 * (i + 1) + k) % 2048;
                end
                f = e + 8;
                s = (v >= f) ? v + 1 : f + 2;
            end else begin
                e_done[v + 1] = 1;
                for (int c = 0; c <= v; c++) e_busy[c] = 1;
                e_end = v + 4;
                e_vlast = v;
            end
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, ".busy"}, busy, 0);
        check({tag, ".done"}, done, 0);
        check({tag, ".mem_rd"}, mem_rd, 0);
        check({tag, ".mem_addr"}, mem_addr, 0);
        check({tag, ".gf_reset"}, gf_reset, 1);
        check({tag, ".gf_pt"}, {gf_X, gf_Y, gf_R}, 0);
        check({tag, ".res_valid"}, res_valid, 0);
        check({tag, ".res_idx"}, res_idx, 0);
        check({tag, ".res_inside"}, res_inside, 0);
        check({tag, ".inside_cnt"}, inside_cnt, 0);
    endtask

    task automatic run(input int n, input bit spur, input int abort_at);
        build(n);
        @(negedge clk);
        start = 1'b1;
        num_obj = 8'(n);
        for (int c = 0; c <= e_end; c++) begin
            @(negedge clk);
            check($sformatf("busy@%0d", c), busy, e_busy[c]);
            check($sformatf("done@%0d", c), done, e_done[c]);
            check($sformatf("mem_rd@%0d", c), mem_rd, e_rd[c]);
            if (e_rd[c])
                check($sformatf("mem_addr@%0d", c), mem_addr, e_addr[c]);
            check($sformatf("gf_reset@%0d", c), gf_reset, e_gfr[c]);
            check($sformatf("gf_pt@%0d", c), {gf_X, gf_Y, gf_R}, e_pt[c]);
            check($sformatf("res_valid@%0d", c), res_valid, e_res[c]);
            if (e_res[c]) begin
                check($sformatf("res_idx@%0d", c), res_idx, e_idx[c]);
                check($sformatf("res_inside@%0d", c), res_inside, e_ins[c]);
            end
            check($sformatf("inside_cnt@%0d", c), inside_cnt, e_cnt[c]);
            if (c == abort_at) begin
                reset = 1'b0;
                start = 1'b0;
                gf_valid = 1'b0;
                #1;
                check_reset_vals("abort");
                @(negedge clk);
                check_reset_vals("abort_hold");
                reset = 1'b1;
                break;
            end
            start = spur && c <= e_vlast && $urandom_range(0, 5) == 0;
            gf_valid = e_gfv[c] ||
                       (spur && !e_win[c] && $urandom_range(0, 3) == 0);
            gf_is_inside = e_gfv[c] ? e_gvin[c] : 1'($urandom);
        end
        start = 1'b0;
        gf_valid = 1'b0;
    endtask

    initial begin
        for (int a = 0; a < 2048; a++) mem[a] = 31'($urandom);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        reset = 1'b1;

        lat[0] = 5; ins[0] = 1;
        run(1, 0, -1);

        for (int i = 0; i < 3; i++) lat[i] = 40;
        ins[0] = 1; ins[1] = 0; ins[2] = 1;
        run(3, 0, -1);

        run(0, 0, -1);

        lat[0] = 3; lat[1] = 7; lat[2] = 8; lat[3] = 1;
        ins[0] = 1; ins[1] = 1; ins[2] = 0; ins[3] = 1;
        run(4, 1, -1);

        lat[0] = 10; lat[1] = 10; ins[0] = 1; ins[1] = 1;
        run(2, 0, 11);
        run(2, 1, -1);

        for (int r = 0; r < 16; r++) begin
            int n;
            n = $urandom_range(0, 5);
            for (int i = 0; i < 8; i++) begin
                lat[i] = $urandom_range(1, 20);
                ins[i] = 1'($urandom);
            end
            run(n, 1'($urandom), -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
